// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encoding and default widths for timer_ctrl
package timer_ctrl_pkg;

  localparam int CW_DEFAULT = 4;
  localparam int EW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (inc && !(&value)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - drives an external loadable counter through start..end periods
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int EW = EW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_start,
  input  logic [CW-1:0] cmd_end,
  input  logic          cmd_periodic,
  input  logic          abort,
  input  logic [CW-1:0] ctr_count,
  output logic          ctr_inc,
  output logic [CW-1:0] ctr_data,
  output logic          busy,
  output logic          expire,
  output logic [EW-1:0] expire_cnt
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] start_q;
  logic [CW-1:0] end_q;
  logic          periodic_q;
  logic          match;
  logic          hit;

  assign match = (state == RUN) && (ctr_count == end_q);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      start_q    <= '0;
      end_q      <= '0;
      periodic_q <= 1'b0;
      expire     <= 1'b0;
    end else begin
      state  <= state_nxt;
      expire <= hit;
      if (cmd_valid && cmd_ready) begin
        start_q    <= cmd_start;
        end_q      <= cmd_end;
        periodic_q <= cmd_periodic;
      end
    end
  end

  // Holding the counter means reloading it with its own value.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ctr_inc   = 1'b0;
    ctr_data  = ctr_count;
    hit       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          ctr_data  = start_q;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (match) begin
          hit = 1'b1;
          if (periodic_q) ctr_data = start_q;
          else            state_nxt = IDLE;
        end else begin
          ctr_inc  = 1'b1;
          ctr_data = start_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter #(
    .WIDTH(EW)
  ) u_expire_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (expire),
    .value   (expire_cnt)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl with a 4-bit loadable counter
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_end;
  logic       cmd_periodic;
  logic       abort;
  logic [3:0] ctr_count;
  logic       ctr_inc;
  logic [3:0] ctr_data;
  logic       busy;
  logic       expire;
  logic [7:0] expire_cnt;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_end      (cmd_end),
    .cmd_periodic (cmd_periodic),
    .abort        (abort),
    .ctr_count    (ctr_count),
    .ctr_inc      (ctr_inc),
    .ctr_data     (ctr_data),
    .busy         (busy),
    .expire       (expire),
    .expire_cnt   (expire_cnt)
  );

  // Downstream counter; resets to a non-zero value so "hold" is observable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ctr_count <= 4'd9;
    else if (ctr_inc) ctr_count <= ctr_count + 4'd1;
    else              ctr_count <= ctr_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    #1;
    if (expire) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_expire", cyc, -1);
      end else begin
        chk("expire_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic p,
                       input logic ab, output int h);
    cmd_start    = s;
    cmd_end      = e;
    cmd_periodic = p;
    abort        = ab;
    cmd_valid    = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    h = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    int h;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_end = '0;
    cmd_periodic = 1'b0; abort = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ctr_inc", ctr_inc, 0);
    chk("rst_ctr_data", ctr_data, 9);
    chk("rst_expire_cnt", expire_cnt, 0);

    // One-shot 3..7, accepted on the first edge after reset release.
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'd3, 4'd7, 1'b0, 1'b0, h);
    #1;
    chk("load_busy", busy, 1);
    chk("load_cmd_ready", cmd_ready, 0);
    chk("load_ctr_inc", ctr_inc, 0);
    chk("load_ctr_data", ctr_data, 3);
    exp_q.push_back(h + 6);
    wait_cyc(h + 5); #1;
    chk("oneshot_match_count", ctr_count, 7);
    chk("oneshot_match_inc", ctr_inc, 0);
    wait_cyc(h + 7); #1;
    chk("oneshot_idle", busy, 0);
    chk("oneshot_hold", ctr_count, 7);
    chk("oneshot_expire_cnt", expire_cnt, 1);

    // Periodic 14..1 wrapping; a command offered mid-run must be ignored.
    issue(4'd14, 4'd1, 1'b1, 1'b0, h);
    for (int k = 0; k < 5; k++) exp_q.push_back(h + 5 + 4 * k);
    for (int j = 0; j < 20; j++) begin
      wait_cyc(h + 1 + j);
      if (j == 2) begin
        cmd_valid = 1'b1; cmd_start = 4'd0; cmd_end = 4'd0; cmd_periodic = 1'b0;
      end
      if (j == 5) cmd_valid = 1'b0;
      #1;
      chk("wrap_count", ctr_count, (14 + j % 4) % 16);
      chk("wrap_cmd_ready", cmd_ready, 0);
    end
    wait_cyc(h + 22);
    abort = 1'b1;
    #1;
    chk("abort_run_inc", ctr_inc, 0);
    chk("abort_run_data", ctr_data, 15);
    wait_cyc(h + 23);
    abort = 1'b0;
    #1;
    chk("abort_run_idle", busy, 0);
    chk("abort_run_hold", ctr_count, 15);
    chk("wrap_expire_cnt", expire_cnt, 6);

    // Abort exactly in the match cycle of a one-shot: no expire.
    issue(4'd3, 4'd7, 1'b0, 1'b0, h);
    wait_cyc(h + 5);
    abort = 1'b1;
    #1;
    chk("abort_match_inc", ctr_inc, 0);
    chk("abort_match_data", ctr_data, 7);
    wait_cyc(h + 6);
    abort = 1'b0;
    #1;
    chk("abort_match_idle", busy, 0);
    wait_cyc(h + 8); #1;
    chk("abort_match_hold", ctr_count, 7);
    chk("abort_match_cnt", expire_cnt, 6);

    // Periodic 5..5 issued together with abort in IDLE, then reset mid-run.
    issue(4'd5, 4'd5, 1'b1, 1'b1, h);
    #1;
    chk("idle_abort_accepted", busy, 1);
    for (int k = 2; k <= 10; k++) exp_q.push_back(h + k);
    wait_cyc(h + 10); #1;
    chk("equal_expire_cnt", expire_cnt, 14);
    wait_cyc(h + 11);
    reset_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ctr_inc", ctr_inc, 0);
    chk("midrst_ctr_data", ctr_data, 9);
    chk("midrst_expire", expire, 0);
    chk("midrst_expire_cnt", expire_cnt, 0);
    wait_cyc(h + 13);
    reset_n = 1'b1;
    wait_cyc(h + 18); #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_hold", ctr_count, 9);

    // 300 back-to-back expires saturate the 8-bit count.
    issue(4'd5, 4'd5, 1'b1, 1'b0, h);
    for (int k = 2; k <= 301; k++) exp_q.push_back(h + k);
    wait_cyc(h + 102); #1;
    chk("sat_mid_cnt", expire_cnt, 100);
    wait_cyc(h + 301);
    abort = 1'b1;
    wait_cyc(h + 302);
    abort = 1'b0;
    #1;
    chk("sat_idle", busy, 0);
    chk("sat_cnt", expire_cnt, 255);
    wait_cyc(h + 305); #1;
    chk("sat_hold", expire_cnt, 255);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
